// File: rtl/bus_glue_pkg.sv
// Shared definitions for the 68030 bus glue.
// Contents:
//   ERR_COUNT_W - width of the saturating fault counter
//   busState_t  - bus watchdog state encoding
//   busTerm()   - decodes any cycle termination from the active-low strobes
package bus_glue_pkg;

  localparam int unsigned ERR_COUNT_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    FAULT = 2'd2,
    DONE  = 2'd3
  } busState_t;

  // Any of DSACK0/1, STERM or AVEC ends the bus cycle normally
  function automatic logic busTerm(input logic [1:0] nDsack,
                                   input logic       nSterm,
                                   input logic       nAvec);
    return !nDsack[1] || !nDsack[0] || !nSterm || !nAvec;
  endfunction

endpackage

// File: rtl/bus_timeout_cfg.sv
// Per-address-space watchdog configuration table.
// Ports:
//   sysClk, nReset  - clock, async active-low reset (all entries -> DEFAULT_TIMEOUT, retry 0)
//   cfgWe/cfgSel    - one-clock write strobe and target space
//   cfgTimeout      - timeout in clocks, 0 disables the watchdog for that space
//   cfgRetry        - first timeout requests a retry (BERR+HALT)
//   rdSel           - space to read
//   rdTimeout_c     - combinational timeout of rdSel
//   rdRetry_c       - combinational retry bit of rdSel
module bus_timeout_cfg #(
  parameter int unsigned CNT_W           = 8,
  parameter int unsigned NUM_SPACES      = 4,
  parameter int unsigned DEFAULT_TIMEOUT = 64
) (
  input  logic                          sysClk,
  input  logic                          nReset,
  input  logic                          cfgWe,
  input  logic [$clog2(NUM_SPACES)-1:0] cfgSel,
  input  logic [CNT_W-1:0]              cfgTimeout,
  input  logic                          cfgRetry,
  input  logic [$clog2(NUM_SPACES)-1:0] rdSel,
  output logic [CNT_W-1:0]              rdTimeout_c,
  output logic                          rdRetry_c
);

  logic [CNT_W-1:0]      timeoutTab [NUM_SPACES];
  logic [NUM_SPACES-1:0] retryTab;

  // Table storage with single write port
  always_ff @(posedge sysClk or negedge nReset) begin
    if (!nReset) begin
      for (int i = 0; i < NUM_SPACES; i++) begin
        timeoutTab[i] <= CNT_W'(DEFAULT_TIMEOUT);
      end
      retryTab <= '0;
    end else if (cfgWe) begin
      timeoutTab[cfgSel] <= cfgTimeout;
      retryTab[cfgSel]   <= cfgRetry;
    end
  end

  // Asynchronous read so IDLE can latch the space's settings on the nAS edge
  assign rdTimeout_c = timeoutTab[rdSel];
  assign rdRetry_c   = retryTab[rdSel];

endmodule

// File: rtl/bus_timeout_ctl.sv
// Bus-cycle watchdog: counts clocks from address strobe and terminates an
// unacknowledged cycle with BERR (optionally BERR+HALT once for a retry).
// Ports:
//   sysClk, nReset      - clock, async active-low reset
//   nAS                 - CPU address strobe (active-low)
//   nDsack/nSterm/nAvec - normal cycle terminations (active-low)
//   spaceSel            - decoded address space, valid while nAS low
//   cfgWe/cfgSel/cfgTimeout/cfgRetry - configuration table write port
//   statClr             - clears sticky fault status
//   nBerr, nHalt        - registered bus error / halt (active-low)
//   errValid/errSpace/errCount - sticky fault status
module bus_timeout_ctl
  import bus_glue_pkg::*;
#(
  parameter int unsigned CNT_W           = 8,
  parameter int unsigned NUM_SPACES      = 4,
  parameter int unsigned DEFAULT_TIMEOUT = 64
) (
  input  logic                          sysClk,
  input  logic                          nReset,
  input  logic                          nAS,
  input  logic [1:0]                    nDsack,
  input  logic                          nSterm,
  input  logic                          nAvec,
  input  logic [$clog2(NUM_SPACES)-1:0] spaceSel,
  input  logic                          cfgWe,
  input  logic [$clog2(NUM_SPACES)-1:0] cfgSel,
  input  logic [CNT_W-1:0]              cfgTimeout,
  input  logic                          cfgRetry,
  input  logic                          statClr,
  output logic                          nBerr,
  output logic                          nHalt,
  output logic                          errValid,
  output logic [$clog2(NUM_SPACES)-1:0] errSpace,
  output logic [ERR_COUNT_W-1:0]        errCount
);

  localparam int unsigned SEL_W = $clog2(NUM_SPACES);

  busState_t        state, stateNxt;
  logic [CNT_W-1:0] count, countNxt;
  logic [SEL_W-1:0] curSpace, spaceNxt;
  logic             curRetry, retryNxt;
  logic             retryPend, pendNxt;
  logic             nBerrNxt, nHaltNxt;
  logic             faultEntry;
  logic             faultRetry;
  logic             term;
  logic [CNT_W-1:0] tabTimeout;
  logic             tabRetry;

  bus_timeout_cfg #(
    .CNT_W          (CNT_W),
    .NUM_SPACES     (NUM_SPACES),
    .DEFAULT_TIMEOUT(DEFAULT_TIMEOUT)
  ) uCfg (
    .sysClk     (sysClk),
    .nReset     (nReset),
    .cfgWe      (cfgWe),
    .cfgSel     (cfgSel),
    .cfgTimeout (cfgTimeout),
    .cfgRetry   (cfgRetry),
    .rdSel      (spaceSel),
    .rdTimeout_c(tabTimeout),
    .rdRetry_c  (tabRetry)
  );

  assign term = busTerm(nDsack, nSterm, nAvec);

  // State, cycle context and bus outputs
  always_ff @(posedge sysClk or negedge nReset) begin
    if (!nReset) begin
      state     <= IDLE;
      count     <= '0;
      curSpace  <= '0;
      curRetry  <= 1'b0;
      retryPend <= 1'b0;
      nBerr     <= 1'b1;
      nHalt     <= 1'b1;
    end else begin
      state     <= stateNxt;
      count     <= countNxt;
      curSpace  <= spaceNxt;
      curRetry  <= retryNxt;
      retryPend <= pendNxt;
      nBerr     <= nBerrNxt;
      nHalt     <= nHaltNxt;
    end
  end

  // Next-state and output decode.
  // count holds the edges still allowed before BERR, so the fault is taken
  // when it reads 1; this places BERR on the T-th edge sampling nAS low,
  // counting the IDLE edge as the first. T=1 therefore faults straight
  // from IDLE.
  always_comb begin
    stateNxt   = state;
    countNxt   = count;
    spaceNxt   = curSpace;
    retryNxt   = curRetry;
    pendNxt    = retryPend;
    nBerrNxt   = 1'b1;
    nHaltNxt   = 1'b1;
    faultEntry = 1'b0;
    faultRetry = 1'b0;

    case (state)
      IDLE: begin
        if (!nAS) begin
          spaceNxt = spaceSel;
          retryNxt = tabRetry;
          countNxt = tabTimeout - CNT_W'(1);
          if (tabTimeout == '0) begin
            stateNxt = DONE;
          end else if (tabTimeout == CNT_W'(1)) begin
            stateNxt = term ? DONE : FAULT;
          end else begin
            stateNxt = COUNT;
          end
        end
      end
      COUNT: begin
        if (nAS) begin
          stateNxt = IDLE;
        end else if (term) begin
          stateNxt = DONE;
        end else if (count == CNT_W'(1)) begin
          stateNxt = FAULT;
        end else begin
          countNxt = count - CNT_W'(1);
        end
      end
      FAULT: begin
        if (nAS) begin
          stateNxt = IDLE;
        end else begin
          nBerrNxt = nBerr;
          nHaltNxt = nHalt;
        end
      end
      DONE: begin
        pendNxt = 1'b0;
        if (nAS) begin
          stateNxt = IDLE;
        end
      end
      default: stateNxt = IDLE;
    endcase

    // Entry into FAULT: first timeout of a retry space asks for a retry
    if (stateNxt == FAULT && state != FAULT) begin
      faultEntry = 1'b1;
      faultRetry = retryNxt && !retryPend;
      pendNxt    = faultRetry;
      nBerrNxt   = 1'b0;
      nHaltNxt   = !faultRetry;
    end
  end

  // Sticky fault status; a fault entry overrides a coincident clear
  always_ff @(posedge sysClk or negedge nReset) begin
    if (!nReset) begin
      errValid <= 1'b0;
      errSpace <= '0;
      errCount <= '0;
    end else if (faultEntry) begin
      errValid <= 1'b1;
      if (statClr || !errValid) begin
        errSpace <= spaceNxt;
      end
      if (statClr) begin
        errCount <= ERR_COUNT_W'(1);
      end else if (errCount != '1) begin
        errCount <= errCount + ERR_COUNT_W'(1);
      end
    end else if (statClr) begin
      errValid <= 1'b0;
      errSpace <= '0;
      errCount <= '0;
    end
  end

endmodule

// File: tb/tb_bus_timeout_ctl.sv
// Self-checking bench for bus_timeout_ctl: directed scenarios followed by
// randomized traffic, all checked against a bus-cycle level reference model.
module tb_bus_timeout_ctl;

  logic       sysClk = 1'b0;
  logic       nReset;
  logic       nAS;
  logic [1:0] nDsack;
  logic       nSterm;
  logic       nAvec;
  logic [1:0] spaceSel;
  logic       cfgWe;
  logic [1:0] cfgSel;
  logic [7:0] cfgTimeout;
  logic       cfgRetry;
  logic       statClr;
  logic       nBerr;
  logic       nHalt;
  logic       errValid;
  logic [1:0] errSpace;
  logic [7:0] errCount;

  bus_timeout_ctl dut (
    .sysClk    (sysClk),
    .nReset    (nReset),
    .nAS       (nAS),
    .nDsack    (nDsack),
    .nSterm    (nSterm),
    .nAvec     (nAvec),
    .spaceSel  (spaceSel),
    .cfgWe     (cfgWe),
    .cfgSel    (cfgSel),
    .cfgTimeout(cfgTimeout),
    .cfgRetry  (cfgRetry),
    .statClr   (statClr),
    .nBerr     (nBerr),
    .nHalt     (nHalt),
    .errValid  (errValid),
    .errSpace  (errSpace),
    .errCount  (errCount)
  );

  always #5 sysClk = ~sysClk;

  int unsigned passed = 0;
  int unsigned total  = 0;
  int unsigned stepNo = 0;

  // Reference model: one bus cycle at a time, tracked by edge number
  int unsigned mTo [4];
  bit          mRe [4];
  bit          act, resolved, faulted, mHalt, pend;
  int unsigned n, cT, cS;
  bit          cR;
  bit          mValid;
  int unsigned mSpace, mCount;

  task automatic modelReset();
    for (int i = 0; i < 4; i++) begin
      mTo[i] = 64;
      mRe[i] = 1'b0;
    end
    act = 0; resolved = 0; faulted = 0; mHalt = 0; pend = 0;
    n = 0; cT = 0; cS = 0; cR = 0;
    mValid = 0; mSpace = 0; mCount = 0;
  endtask

  // Applies the rules for one rising edge using the inputs sampled there
  task automatic modelEdge();
    bit t;
    bit fault;
    t = (nDsack != 2'b11) || !nSterm || !nAvec;
    fault = 0;
    if (!act) begin
      if (!nAS) begin
        act = 1; n = 1;
        cT = mTo[spaceSel]; cR = mRe[spaceSel]; cS = 32'(spaceSel);
        resolved = 0; faulted = 0;
      end
    end else if (nAS) begin
      act = 0;
    end else begin
      n++;
    end
    if (act && !resolved) begin
      if (cT == 0) begin
        resolved = 1; pend = 0;
      end else if (t && (n >= 2 || cT == 1)) begin
        resolved = 1; pend = 0;
      end else if (n == cT) begin
        resolved = 1; faulted = 1; fault = 1;
        mHalt = cR && !pend;
        pend = mHalt;
      end
    end
    if (fault) begin
      if (statClr || !mValid) mSpace = cS;
      mCount = statClr ? 1 : (mCount < 255 ? mCount + 1 : 255);
      mValid = 1;
    end else if (statClr) begin
      mValid = 0; mSpace = 0; mCount = 0;
    end
    if (cfgWe) begin
      mTo[cfgSel] = 32'(cfgTimeout);
      mRe[cfgSel] = cfgRetry;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s step=%0d observed=%0h expected=%0h", tag, stepNo, obs, exp);
  endtask

  task automatic checkAll();
    chk("nBerr",    32'(nBerr),    32'(!(act && faulted)));
    chk("nHalt",    32'(nHalt),    32'(!(act && faulted && mHalt)));
    chk("errValid", 32'(errValid), 32'(mValid));
    chk("errSpace", 32'(errSpace), mSpace);
    chk("errCount", 32'(errCount), mCount);
  endtask

  task automatic step();
    @(posedge sysClk);
    stepNo++;
    modelEdge();
    #1;
    checkAll();
  endtask

  task automatic idleIn();
    nDsack = 2'b11; nSterm = 1'b1; nAvec = 1'b1;
    cfgWe = 1'b0; statClr = 1'b0;
  endtask

  task automatic cyc(input bit nas, input logic [1:0] sel, input int cnt);
    nAS = nas; spaceSel = sel;
    for (int i = 0; i < cnt; i++) step();
  endtask

  task automatic writeCfg(input logic [1:0] sel, input logic [7:0] to, input bit re);
    cfgWe = 1'b1; cfgSel = sel; cfgTimeout = to; cfgRetry = re;
    step();
    cfgWe = 1'b0;
  endtask

  initial begin
    nReset = 1'b0; nAS = 1'b1; spaceSel = 2'd0; cfgSel = 2'd0;
    cfgTimeout = 8'd0; cfgRetry = 1'b0;
    idleIn();
    modelReset();
    #23;
    chk("rst_nBerr", 32'(nBerr), 32'd1);
    chk("rst_nHalt", 32'(nHalt), 32'd1);
    chk("rst_errValid", 32'(errValid), 32'd0);
    chk("rst_errCount", 32'(errCount), 32'd0);
    @(negedge sysClk); nReset = 1'b1;
    cyc(1, 0, 2);

    // Default 64-clock timeout in space 0
    cyc(0, 0, 63);
    chk("def_edge63", 32'(nBerr), 32'd1);
    cyc(0, 0, 1);
    chk("def_edge64", 32'(nBerr), 32'd0);
    chk("def_halt", 32'(nHalt), 32'd1);
    cyc(1, 0, 1);
    chk("def_release", 32'(nBerr), 32'd1);
    chk("def_count", 32'(errCount), 32'd1);

    // DSACK on the 5th edge
    cyc(0, 1, 4);
    nDsack = 2'b10; step(); nDsack = 2'b11;
    cyc(0, 1, 80);
    chk("dsack_noberr", 32'(nBerr), 32'd1);
    cyc(1, 1, 2);
    // STERM exactly on the 64th edge
    cyc(0, 1, 63);
    nSterm = 1'b0; step(); nSterm = 1'b1;
    chk("term64_noberr", 32'(nBerr), 32'd1);
    cyc(0, 1, 3);
    cyc(1, 1, 2);
    chk("term_count", 32'(errCount), 32'd1);

    // Retry space: first timeout BERR+HALT, second BERR only
    writeCfg(2, 8'd3, 1'b1);
    cyc(0, 2, 2);
    chk("retry_e2", 32'(nBerr), 32'd1);
    cyc(0, 2, 1);
    chk("retry_berr", 32'(nBerr), 32'd0);
    chk("retry_halt", 32'(nHalt), 32'd0);
    cyc(0, 2, 3);
    cyc(1, 2, 1);
    cyc(0, 2, 3);
    chk("final_berr", 32'(nBerr), 32'd0);
    chk("final_halt", 32'(nHalt), 32'd1);
    cyc(1, 2, 1);
    chk("retry_count", 32'(errCount), 32'd3);
    chk("retry_space", 32'(errSpace), 32'd0);
    statClr = 1'b1; step(); statClr = 1'b0;
    cyc(0, 2, 3); cyc(1, 2, 1); cyc(0, 2, 3); cyc(1, 2, 1);
    chk("retry2_count", 32'(errCount), 32'd2);
    chk("retry2_space", 32'(errSpace), 32'd2);

    // Disabled watchdog
    writeCfg(1, 8'd0, 1'b0);
    cyc(0, 1, 300);
    chk("disabled_noberr", 32'(nBerr), 32'd1);
    cyc(1, 1, 1);

    // Counter saturation, then clear coinciding with a fault
    writeCfg(3, 8'd1, 1'b0);
    for (int k = 0; k < 260; k++) begin
      cyc(0, 3, 1);
      cyc(1, 3, 1);
    end
    chk("sat_count", 32'(errCount), 32'd255);
    statClr = 1'b1; cyc(0, 3, 1); statClr = 1'b0;
    chk("clr_fault_count", 32'(errCount), 32'd1);
    chk("clr_fault_valid", 32'(errValid), 32'd1);
    chk("clr_fault_space", 32'(errSpace), 32'd3);
    cyc(1, 3, 1);

    // Randomized traffic with small random timeouts
    for (int s = 0; s < 4; s++) begin
      writeCfg(2'(s), 8'($urandom_range(0, 8)), 1'($urandom_range(0, 1)));
    end
    for (int r = 0; r < 2500; r++) begin
      if ($urandom_range(0, 7) == 0) nAS = ~nAS;
      spaceSel = 2'($urandom_range(0, 3));
      nDsack   = ($urandom_range(0, 11) == 0) ? 2'($urandom_range(0, 2)) : 2'b11;
      nSterm   = ($urandom_range(0, 24) != 0);
      nAvec    = ($urandom_range(0, 40) != 0);
      statClr  = ($urandom_range(0, 39) == 0);
      cfgWe    = ($urandom_range(0, 15) == 0);
      cfgSel   = 2'($urandom_range(0, 3));
      cfgTimeout = 8'($urandom_range(0, 8));
      cfgRetry = 1'($urandom_range(0, 1));
      step();
    end
    idleIn();
    cyc(1, 0, 2);

    // Reset asserted while BERR is driven
    writeCfg(2, 8'd2, 1'b0);
    cyc(0, 2, 2);
    chk("pre_rst_berr", 32'(nBerr), 32'd0);
    #2;
    nReset = 1'b0;
    #1;
    chk("async_rst_berr", 32'(nBerr), 32'd1);
    chk("async_rst_halt", 32'(nHalt), 32'd1);
    chk("async_rst_valid", 32'(errValid), 32'd0);
    modelReset();
    nAS = 1'b1;
    @(negedge sysClk); nReset = 1'b1;
    cyc(1, 2, 1);
    cyc(0, 2, 63);
    chk("post_rst_e63", 32'(nBerr), 32'd1);
    cyc(0, 2, 1);
    chk("post_rst_e64", 32'(nBerr), 32'd0);
    cyc(1, 2, 2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
